// File: rtl/seven_segment_scan_controller_if.sv
// Requester-side handshake bundle for the seven-segment scan controller.
// Carries the packed hex value, its update request and the capture ack.
interface seven_segment_scan_controller_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                value_ack;

    modport master (
        output value,
        output value_valid,
        input  value_ack
    );

    modport slave (
        input  value,
        input  value_valid,
        output value_ack
    );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed 7-segment scanner with frame-boundary value snapshot.
// Optional leading-zero suppression: define SEVEN_SEGMENT_LZ_BLANK_EN.
module seven_segment_scan_controller #(
    parameter int DIGITS = 4,
    parameter int DIV    = 12000,
    parameter int BLANK  = 120
) (
    input  logic                        clock,
    input  logic                        reset_n,
    seven_segment_scan_controller_if.slave bus,
    output logic [6:0]                  abcdefg,
    output logic [DIGITS-1:0]           digit_en,
    output logic                        frame_start
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(DIV);

    typedef enum logic [1:0] {
        S_INIT,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [DW-1:0]       r_d;
    logic [DW-1:0]       w_d_n;
    logic [TW-1:0]       r_t;
    logic [TW-1:0]       w_t_n;
    logic [4*DIGITS-1:0] r_snap;
    logic [4*DIGITS-1:0] w_snap_n;
    logic                w_boundary;

    logic                r_ack;
    logic                w_ack_n;
    logic                r_fs;
    logic                w_fs_n;
    logic [6:0]          r_seg;
    logic [6:0]          w_seg_n;
    logic [DIGITS-1:0]   r_en;
    logic [DIGITS-1:0]   w_en_n;
    logic [3:0]          w_nib;
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
    logic                w_sup;
`endif

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Next-state: slot timer, digit index, frame boundary and snapshot load.
    always_comb begin
        w_state_n  = r_state;
        w_d_n      = r_d;
        w_t_n      = r_t;
        w_boundary = 1'b0;
        case (r_state)
            S_INIT: begin
                w_state_n  = S_BLANK;
                w_d_n      = '0;
                w_t_n      = '0;
                w_boundary = 1'b1;
            end
            S_BLANK: begin
                w_t_n = r_t + 1'b1;
                if (r_t == TW'(BLANK - 1)) begin
                    w_state_n = S_SHOW;
                end
            end
            S_SHOW: begin
                if (r_t == TW'(DIV - 1)) begin
                    w_t_n     = '0;
                    w_state_n = S_BLANK;
                    if (r_d == DW'(DIGITS - 1)) begin
                        w_d_n      = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_d_n = r_d + 1'b1;
                    end
                end else begin
                    w_t_n = r_t + 1'b1;
                end
            end
            default: begin
                w_state_n = S_INIT;
                w_d_n     = '0;
                w_t_n     = '0;
            end
        endcase
        w_fs_n   = w_boundary;
        w_ack_n  = w_boundary & bus.value_valid;
        w_snap_n = w_ack_n ? bus.value : r_snap;
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        w_nib  = 4'h0;
        w_en_n = '0;
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
        w_sup  = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (DW'(i) == w_d_n) begin
                w_nib     = w_snap_n[4*i +: 4];
                w_en_n[i] = (w_state_n == S_SHOW);
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
                w_sup     = (i != 0) && ~|(w_snap_n >> (4*i));
`endif
            end
        end
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
        w_seg_n = (w_state_n == S_SHOW && !w_sup) ? hex_seg(w_nib) : 7'd0;
`else
        w_seg_n = (w_state_n == S_SHOW) ? hex_seg(w_nib) : 7'd0;
`endif
    end

    // Control state: FSM, digit index, slot timer and frame snapshot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
            r_d     <= '0;
            r_t     <= '0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_n;
            r_d     <= w_d_n;
            r_t     <= w_t_n;
            r_snap  <= w_snap_n;
        end
    end

    // Registered outputs, cleared immediately by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack <= 1'b0;
            r_fs  <= 1'b0;
            r_seg <= '0;
            r_en  <= '0;
        end else begin
            r_ack <= w_ack_n;
            r_fs  <= w_fs_n;
            r_seg <= w_seg_n;
            r_en  <= w_en_n;
        end
    end

    assign bus.value_ack = r_ack;
    assign frame_start   = r_fs;
    assign abcdefg       = r_seg;
    assign digit_en      = r_en;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the seven-segment scan controller (4 digits, DIV 8,
// BLANK 2) with a capture scoreboard and a frame-position timing model.
module tb_seven_segment_scan_controller;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] abcdefg;
    logic [3:0] digit_en;
    logic       frame_start;

    seven_segment_scan_controller_if #(.DIGITS(DIGITS)) bus ();

    seven_segment_scan_controller #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .abcdefg    (abcdefg),
        .digit_en   (digit_en),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int          k     = 0;
    int          zrun  = 0;
    bit          seen_show = 1'b0;
    logic [15:0] exp_snap  = 16'h0000;
    logic [15:0] sb[$];
    logic [6:0]  SEG[16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h k=%0d",
                   tag, obs, exp, k);
        end
    endtask

    task automatic request(input logic [15:0] v);
        bus.value       = v;
        bus.value_valid = 1'b1;
        sb.push_back(v);
    endtask

    task automatic withdraw();
        bus.value_valid = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
    endtask

    task automatic step();
        logic       v;
        int         p;
        int         slot;
        int         w;
        logic       exp_ack;
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        @(posedge clock);
        v = bus.value_valid;
        #1;
        k++;
        p    = (k - 1) % FRAME;
        slot = p / DIV;
        w    = p % DIV;
        exp_ack = (p == 0) && v;
        if (exp_ack) begin
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) exp_snap = sb.pop_front();
            bus.value_valid = 1'b0;
        end
        exp_en  = (w < BLANK) ? 4'b0000 : (4'b0001 << slot);
        exp_seg = (w < BLANK) ? 7'd0 : SEG[exp_snap[slot*4 +: 4]];
`ifdef SEVEN_SEGMENT_LZ_BLANK_EN
        if (w >= BLANK && slot > 0 && (exp_snap >> (4*slot)) == 16'd0)
            exp_seg = 7'd0;
`endif
        chk("frame_start", 32'(frame_start), 32'(p == 0));
        chk("value_ack", 32'(bus.value_ack), 32'(exp_ack));
        chk("digit_en", 32'(digit_en), 32'(exp_en));
        chk("abcdefg", 32'(abcdefg), 32'(exp_seg));
        chk("onehot", 32'($onehot0(digit_en)), 32'd1);
        if (digit_en == 4'b0000) begin
            zrun++;
        end else begin
            if (seen_show && zrun > 0) chk("blank_gap", 32'(zrun), 32'(BLANK));
            zrun      = 0;
            seen_show = 1'b1;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.value       = 16'h0000;
        bus.value_valid = 1'b0;
        #2;
        chk("rst_seg", 32'(abcdefg), 32'd0);
        chk("rst_en", 32'(digit_en), 32'd0);
        chk("rst_ack", 32'(bus.value_ack), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        #20;
        reset_n = 1'b1;

        // 1: idle scanning of snapshot 0, frame_start at k=1 and k=33
        steps(40);

        // 2: 12AF captured at next boundary, requester drops on ack
        request(16'h12AF);
        steps(60);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // 3: mid-frame valid pulse is ignored
        while (((k - 1) % FRAME) != 10) step();
        request(16'h5555);
        steps(3);
        withdraw();
        steps(2 * FRAME + 4);

        // 4: reset during SHOW of digit 2 clears outputs without an edge
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (((k - 1) % FRAME) == 2 * DIV + 4) break;
            step();
        end
        chk("show_d2", 32'(digit_en), 32'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(abcdefg), 32'd0);
        chk("mid_rst_en", 32'(digit_en), 32'd0);
        chk("mid_rst_ack", 32'(bus.value_ack), 32'd0);
        chk("mid_rst_fs", 32'(frame_start), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n   = 1'b1;
        k         = 0;
        zrun      = 0;
        seen_show = 1'b0;
        exp_snap  = 16'h0000;
        sb.delete();
        steps(FRAME + 4);

        // 5: leading-zero value
        request(16'h0030);
        steps(FRAME + 2);

        // 6: four full frames of gap / one-hot checks
        steps(4 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
